bsg_manycore_npa_to_eva: RTL and testbench

BSG_MANYCORE_NPA_TO_EVA -- requirements
Module: bsg_manycore_npa_to_eva

---
 rtl/bsg_manycore_npa_to_eva.sv | 169 ++++++++++++++++
 tb/tb_bsg_manycore_npa_to_eva.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_npa_to_eva.sv
// Converts a manycore network physical address (x, y, word EPA) into a byte EVA and buffers the
// result in a 2-entry FIFO. Optional invalid-entry counter: BSG_MANYCORE_NPA_TO_EVA_STATS_EN.
module bsg_manycore_npa_to_eva #(
  // The instantiator sets every parameter. The defaults only keep a standalone elaboration legal.
  parameter int addr_width_p   = 16,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int num_tiles_y_p  = 4,
  parameter int vcache_size_p  = 1024,
  parameter int data_width_p   = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  input  logic [x_cord_width_p-1:0] x_cord_i,
  input  logic [y_cord_width_p-1:0] y_cord_i,
  input  logic [addr_width_p-1:0]   epa_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [data_width_p-1:0]   eva_o,
  output logic                      is_invalid_addr_o,
  input  logic                      yumi_i
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
  ,
  output logic [31:0]               invalid_count_o
`endif
);

  localparam int max_x_cord_width_gp    = 6;
  localparam int max_y_cord_width_gp    = 6;
  localparam int epa_word_addr_width_gp = 16;
  localparam int vcache_lg_lp           = $clog2(vcache_size_p);
  localparam logic [y_cord_width_p-1:0] vcache_south_y_lp = y_cord_width_p'(num_tiles_y_p + 1);

  typedef struct packed {
    logic [1:0]                        remote;
    logic [max_y_cord_width_gp-1:0]    y_cord;
    logic [max_x_cord_width_gp-1:0]    x_cord;
    logic [epa_word_addr_width_gp-1:0] addr;
    logic [1:0]                        low_bits;
  } bsg_manycore_global_addr_s;

  // The host window keeps epa[addr_width_p-2:0] plus two byte bits below the 2-bit prefix.
  if (addr_width_p + 1 > 30) begin : g_host_width_check
    $error("bsg_manycore_npa_to_eva: addr_width_p + 1 must be <= 30");
  end

  // Classification, first match wins: host, vcache, tile, invalid.
  logic is_host;
  logic is_vcache;
  logic is_tile;
  logic vcache_row;

  assign vcache_row = (y_cord_i == '0) || (y_cord_i == vcache_south_y_lp);

  assign is_host = (y_cord_i == y_cord_width_p'(1))
                 && (x_cord_i == '0)
                 && epa_i[addr_width_p-1];

  assign is_vcache = vcache_row
                   && !epa_i[addr_width_p-1]
                   && ((epa_i >> vcache_lg_lp) == '0);

  assign is_tile = (y_cord_i >= y_cord_width_p'(1))
                 && (y_cord_i <= y_cord_width_p'(num_tiles_y_p))
                 && ((x_cord_i >> max_x_cord_width_gp) == '0)
                 && ((y_cord_i >> max_y_cord_width_gp) == '0)
                 && ((epa_i >> epa_word_addr_width_gp) == '0);

  bsg_manycore_global_addr_s tile_addr;
  logic [data_width_p-1:0]   conv_eva;
  logic                      conv_invalid;

  always_comb begin
    tile_addr          = '0;
    tile_addr.remote   = 2'b01;
    tile_addr.y_cord   = max_y_cord_width_gp'(y_cord_i);
    tile_addr.x_cord   = max_x_cord_width_gp'(x_cord_i);
    tile_addr.addr     = epa_word_addr_width_gp'(epa_i);
    tile_addr.low_bits = 2'b00;

    conv_eva     = '0;
    conv_invalid = 1'b0;
    if (is_host) begin
      conv_eva[data_width_p-1 -: 2]    = 2'b11;
      conv_eva[2 +: addr_width_p-1]    = epa_i[addr_width_p-2:0];
    end else if (is_vcache) begin
      conv_eva[data_width_p-1 -: 2]                        = 2'b10;
      conv_eva[2 +: vcache_lg_lp]                          = epa_i[vcache_lg_lp-1:0];
      conv_eva[2+vcache_lg_lp +: x_cord_width_p]           = x_cord_i;
      conv_eva[2+vcache_lg_lp+x_cord_width_p]              = (y_cord_i != '0);
    end else if (is_tile) begin
      conv_eva = data_width_p'(tile_addr);
    end else begin
      conv_invalid = 1'b1;
    end
  end

  // Handshake: a word enters on v_i & ready_o and leaves on v_o & yumi_i. ready_o is a flop that
  // depends only on the occupancy, and yumi_i is legal only while v_o is high.
  logic [data_width_p-1:0] eva_mem [2];
  logic [1:0]              inv_mem;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic [1:0]              count_next;
  logic                    ready_r;
  logic                    enq;
  logic                    deq;

  assign enq = v_i & ready_r;
  assign deq = yumi_i & v_o;

  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      count   <= count_next;
      ready_r <= (count_next != 2'd2);
      if (enq) begin
        eva_mem[wr_ptr] <= conv_eva;
        inv_mem[wr_ptr] <= conv_invalid;
        wr_ptr          <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // An empty FIFO presents zeros, which also covers the cycles following a reset.
  assign ready_o           = ready_r;
  assign v_o               = (count != 2'd0);
  assign eva_o             = v_o ? eva_mem[rd_ptr] : '0;
  assign is_invalid_addr_o = v_o ? inv_mem[rd_ptr] : 1'b0;

`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
  logic [31:0] invalid_count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      invalid_count_r <= '0;
    end else if (enq && conv_invalid && (invalid_count_r != 32'hFFFF_FFFF)) begin
      invalid_count_r <= invalid_count_r + 32'd1;
    end
  end

  assign invalid_count_o = invalid_count_r;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!yumi_i || v_o);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_npa_to_eva.sv
// Self-checking bench for bsg_manycore_npa_to_eva: directed boundary cases followed by random
// traffic, with expected values taken from an address-arithmetic model and an expected queue.
module tb_bsg_manycore_npa_to_eva;

  localparam int addr_width_lp   = 16;
  localparam int x_cord_width_lp = 4;
  localparam int y_cord_width_lp = 4;
  localparam int num_tiles_y_lp  = 4;
  localparam int vcache_size_lp  = 1024;
  localparam int vcache_lg_lp    = 10;
  localparam int data_width_lp   = 32;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       v = 1'b0;
  logic [x_cord_width_lp-1:0] x_cord = '0;
  logic [y_cord_width_lp-1:0] y_cord = '0;
  logic [addr_width_lp-1:0]   epa = '0;
  logic                       yumi = 1'b0;
  logic                       ready;
  logic                       v_out;
  logic [data_width_lp-1:0]   eva;
  logic                       is_invalid;
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
  logic [31:0]                invalid_count;
  logic [31:0]                mdl_inv_count = '0;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  bsg_manycore_npa_to_eva #(
    .addr_width_p   (addr_width_lp),
    .x_cord_width_p (x_cord_width_lp),
    .y_cord_width_p (y_cord_width_lp),
    .num_tiles_y_p  (num_tiles_y_lp),
    .vcache_size_p  (vcache_size_lp),
    .data_width_p   (data_width_lp)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .v_i               (v),
    .x_cord_i          (x_cord),
    .y_cord_i          (y_cord),
    .epa_i             (epa),
    .ready_o           (ready),
    .v_o               (v_out),
    .eva_o             (eva),
    .is_invalid_addr_o (is_invalid),
    .yumi_i            (yumi)
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
    ,
    .invalid_count_o   (invalid_count)
`endif
  );

  // scoreboard: each entry is {invalid, eva}
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic        mdl_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Address rules as arithmetic, first match wins.
  function automatic logic [32:0] ref_npa(input int x, input int y, input int e);
    longint r;
    if (y == 1 && x == 0 && e >= 2 ** (addr_width_lp - 1)) begin
      r = 64'hC000_0000 + longint'(e % (2 ** (addr_width_lp - 1))) * 4;
    end else if ((y == 0 || y == num_tiles_y_lp + 1) && e < vcache_size_lp) begin
      r = 64'h8000_0000 + longint'(e) * 4 + longint'(x) * (2 ** (2 + vcache_lg_lp))
        + ((y != 0) ? longint'(2 ** (2 + vcache_lg_lp + x_cord_width_lp)) : 64'd0);
    end else if (y >= 1 && y <= num_tiles_y_lp && x < 64 && y < 64 && e < 65536) begin
      r = 64'h4000_0000 + longint'(y) * (2 ** 24) + longint'(x) * (2 ** 18) + longint'(e) * 4;
    end else begin
      return {1'b1, 32'h0};
    end
    return {1'b0, r[31:0]};
  endfunction

  // One clock: predict the transfers from the inputs in force, advance, then compare.
  task automatic step();
    bit          rst;
    bit          in_x;
    bit          out_x;
    logic [32:0] r;
    rst   = !reset_n;
    in_x  = v && mdl_ready;
    out_x = yumi && (exp_q.size() != 0);
    r     = ref_npa(int'(x_cord), int'(y_cord), int'(epa));
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      mdl_ready = 1'b0;
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
      mdl_inv_count = '0;
`endif
    end else begin
      if (out_x) void'(exp_q.pop_front());
      if (in_x) begin
        exp_q.push_back(r);
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
        if (r[32] && mdl_inv_count != 32'hFFFF_FFFF) mdl_inv_count++;
`endif
      end
      mdl_ready = (exp_q.size() < 2);
    end
    check("ready", 32'(ready), 32'(mdl_ready));
    check("v_o", 32'(v_out), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("eva", eva, exp_q[0][31:0]);
      check("invalid", 32'(is_invalid), 32'(exp_q[0][32]));
    end else begin
      check("eva_idle", eva, 32'h0);
      check("invalid_idle", 32'(is_invalid), 32'h0);
    end
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
    check("invalid_count", invalid_count, mdl_inv_count);
`endif
  endtask

  // driver tasks
  task automatic drive(input bit vv, input int xx, input int yy, input int ee, input bit yu);
    v      = vv;
    x_cord = x_cord_width_lp'(xx);
    y_cord = y_cord_width_lp'(yy);
    epa    = addr_width_lp'(ee);
    yumi   = yu;
  endtask

  task automatic drain();
    int n;
    n = 0;
    v = 1'b0;
    while (exp_q.size() != 0 && n < 8) begin
      yumi = 1'b1;
      step();
      n++;
    end
    yumi = 1'b0;
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    step();
    step();
    check("reset_ready_low", 32'(ready), 32'h0);
    reset_n = 1'b1;
    step();
    check("ready_after_release", 32'(ready), 32'h1);

    // tile, vcache, invalid, host and class boundaries
    drive(1, 2, 3, 'h104, 0);  step(); check("tile_eva", eva, 32'h4308_0410);
    drain();
    drive(1, 5, 5, 'h3FF, 0);  step(); check("vcache_eva", eva, 32'h8001_5FFC);
    drain();
    drive(1, 0, 7, 0, 0);      step(); check("invalid_flag", 32'(is_invalid), 32'h1);
    check("invalid_eva", eva, 32'h0);
`ifdef BSG_MANYCORE_NPA_TO_EVA_STATS_EN
    check("invalid_count_one", invalid_count, 32'h1);
`endif
    drain();
    drive(1, 0, 1, 'h8005, 0); step(); check("host_eva", eva, 32'hC000_0014);
    drain();
    drive(1, 3, 0, 'h400, 0);  step(); check("vcache_oor_invalid", 32'(is_invalid), 32'h1);
    drain();
    drive(1, 3, 0, 'h3FF, 0);  step(); check("vcache_y0_eva", eva, 32'h8000_3FFC);
    drain();
    drive(1, 0, 1, 'h7FFF, 0); step(); check("tile_not_host", eva, 32'h4101_FFFC);
    drain();

    // backpressure: three back-to-back, consumer stalled
    drive(1, 1, 2, 'h20, 0);   step();
    drive(1, 2, 0, 'h11, 0);   step();
    drive(1, 0, 9, 'h0, 0);    step();
    check("bp_ready_low", 32'(ready), 32'h0);
    check("bp_head_hold", eva, 32'h4204_0080);
    step();
    check("bp_head_still", eva, 32'h4204_0080);
    yumi = 1'b1;               step();
    check("bp_second", eva, 32'h8000_2044);
    step();
    check("bp_third_invalid", 32'(is_invalid), 32'h1);
    drain();

    // simultaneous enqueue/dequeue at occupancy 1
    drive(1, 3, 4, 'h1, 0);    step();
    drive(1, 0, 1, 'hFFFF, 1); step();
    check("simul_eva", eva, 32'hC001_FFFC);
    check("simul_occupancy", 32'(exp_q.size()), 32'h1);
    drain();

    // reset with two entries buffered
    drive(1, 1, 1, 'h5, 0);    step();
    drive(1, 2, 2, 'h6, 0);    step();
    v = 1'b0;
    reset_n = 1'b0;            step();
    check("rst_mid_v", 32'(v_out), 32'h0);
    reset_n = 1'b1;            step();
    check("rst_mid_ready", 32'(ready), 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      int xx;
      int yy;
      int ee;
      kind = $urandom_range(0, 3);
      xx   = $urandom_range(0, 15);
      ee   = $urandom_range(0, 65535);
      case (kind)
        0: begin yy = 1; xx = ($urandom_range(0, 3) == 0) ? xx : 0; ee = ee | 'h8000; end
        1: begin
          yy = ($urandom_range(0, 1) == 0) ? 0 : num_tiles_y_lp + 1;
          ee = ($urandom_range(0, 3) == 0) ? ee : (ee % vcache_size_lp);
        end
        2: yy = $urandom_range(1, num_tiles_y_lp);
        default: yy = $urandom_range(0, 15);
      endcase
      reset_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, xx, yy, ee,
            (exp_q.size() != 0) ? ($urandom_range(0, 2) != 0) : 1'b0);
      step();
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
